// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the ALU issue stage and its upstream producer / downstream consumer.
// The master side issues operations and consumes results; the slave side is the stage itself.
interface alu_issue_stage_if #(
  parameter int W   = 3,
  parameter int OPW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_opcode;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [W-1:0]   in_c_in;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_y;
  logic [3:0]     out_flags;

  modport master (
    output in_valid, in_opcode, in_a, in_b, in_c_in, out_ready,
    input  in_ready, out_valid, out_y, out_flags
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_c_in, out_ready,
    output in_ready, out_valid, out_y, out_flags
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Registers one operation onto the combinational ALU for a full settle cycle, captures its result
// and flags, and hands them downstream with a sticky carry/overflow status and a completion counter.
module alu_issue_stage #(
  parameter int W   = 3,
  parameter int OPW = 4,
  parameter int CW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_stage_if.slave  bus,
  output logic [OPW-1:0]    alu_opcode,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [W-1:0]      alu_c_in,
  input  logic [W-1:0]      alu_y,
  input  logic              alu_c_out,
  input  logic              alu_v,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              clr_sticky,
  output logic [1:0]        sticky_cv,
  output logic [CW-1:0]     op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic            in_ready_s;
  logic            load_s;
  logic            capture_s;
  logic            handoff_s;
  logic            out_valid_r;
  logic [W-1:0]    out_y_r;
  logic [3:0]      out_flags_r;
  logic [1:0]      sticky_r;
  logic [CW-1:0]   op_count_r;
  logic [OPW-1:0]  alu_opcode_r;
  logic [W-1:0]    alu_a_r;
  logic [W-1:0]    alu_b_r;
  logic [W-1:0]    alu_c_in_r;

  // Next-state and handshake decode; DONE forwards downstream readiness so a handoff can reload at once.
  always_comb begin
    state_next_s = state_r;
    in_ready_s   = 1'b0;
    load_s       = 1'b0;
    capture_s    = 1'b0;
    handoff_s    = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          load_s       = 1'b1;
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        capture_s    = 1'b1;
        state_next_s = DONE;
      end
      DONE: begin
        in_ready_s = bus.out_ready;
        if (bus.out_ready) begin
          handoff_s = 1'b1;
          if (bus.in_valid) begin
            load_s       = 1'b1;
            state_next_s = ISSUE;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register plus all datapath, status and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      out_valid_r  <= 1'b0;
      alu_opcode_r <= {OPW{1'b0}};
      alu_a_r      <= {W{1'b0}};
      alu_b_r      <= {W{1'b0}};
      alu_c_in_r   <= {W{1'b0}};
      out_y_r      <= {W{1'b0}};
      out_flags_r  <= 4'b0000;
      sticky_r     <= 2'b00;
      op_count_r   <= {CW{1'b0}};
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s == DONE);
      if (load_s) begin
        alu_opcode_r <= bus.in_opcode;
        alu_a_r      <= bus.in_a;
        alu_b_r      <= bus.in_b;
        alu_c_in_r   <= bus.in_c_in;
      end
      if (capture_s) begin
        out_y_r     <= alu_y;
        out_flags_r <= {alu_c_out, alu_v, alu_n, alu_z};
      end
      // Clear is applied before the capture OR so a coincident set survives.
      sticky_r <= (clr_sticky ? 2'b00 : sticky_r) |
                  (capture_s ? {alu_c_out, alu_v} : 2'b00);
      if (handoff_s) begin
        op_count_r <= op_count_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_y     = out_y_r;
  assign bus.out_flags = out_flags_r;
  assign alu_opcode    = alu_opcode_r;
  assign alu_a         = alu_a_r;
  assign alu_b         = alu_b_r;
  assign alu_c_in      = alu_c_in_r;
  assign sticky_cv     = sticky_r;
  assign op_count      = op_count_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage, checked against a transaction-level model
// of the stage together with a small behavioural ALU.
module tb_alu_issue_stage;
  localparam int W   = 3;
  localparam int OPW = 4;
  localparam int CW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           clr_sticky;
  logic [OPW-1:0] alu_opcode;
  logic [W-1:0]   alu_a, alu_b, alu_c_in;
  logic [W-1:0]   alu_y;
  logic           alu_c_out, alu_v, alu_n, alu_z;
  logic [1:0]     sticky_cv;
  logic [CW-1:0]  op_count;

  alu_issue_stage_if #(.W(W), .OPW(OPW)) bus ();

  alu_issue_stage #(.W(W), .OPW(OPW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
    .alu_y(alu_y), .alu_c_out(alu_c_out), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
    .clr_sticky(clr_sticky), .sticky_cv(sticky_cv), .op_count(op_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Model: an op is either being issued (ALU settling) or held as a result awaiting handoff.
  bit             m_issuing, m_holding, m_acc, force_v;
  logic [W-1:0]   m_y;
  logic [3:0]     m_flags;
  logic [1:0]     m_sticky;
  int             m_count;
  logic [OPW-1:0] m_op;
  logic [W-1:0]   m_a, m_b, m_c;

  // Behavioural ALU: returns {c_out, v, n, z, y}.
  function automatic logic [W+3:0] alu_ref(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] cin);
    logic [2*W-1:0] t;
    logic [W:0]     s;
    logic [W-1:0]   y;
    logic           c, v;
    t = '0; s = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin t = {{W{1'b0}}, a} << b; y = t[W-1:0]; c = |t[2*W-1:W]; end
      4'd1: begin y = a >> b; end
      4'd2: begin s = {1'b0, a} + {1'b0, b} + {1'b0, cin}; y = s[W-1:0]; c = s[W];
                  v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]); end
      4'd3: begin s = {1'b0, a} - {1'b0, b}; y = s[W-1:0]; c = s[W];
                  v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]); end
      default: y = a ^ b;
    endcase
    return {c, v, y[W-1], (y == '0), y};
  endfunction

  task automatic model_reset();
    m_issuing = 0; m_holding = 0; m_y = '0; m_flags = '0; m_sticky = '0; m_count = 0;
    m_op = '0; m_a = '0; m_b = '0; m_c = '0;
  endtask

  // One clock: drive the ALU, check in_ready, advance the model at the edge, then check all outputs.
  task automatic cycle();
    logic [W+3:0] r;
    bit exp_ready, ho;
    exp_ready = !m_issuing && (!m_holding || bus.out_ready);
    if (m_issuing) begin
      r = alu_ref(m_op, m_a, m_b, m_c);
      alu_y = r[W-1:0];
      {alu_c_out, alu_v, alu_n, alu_z} = r[W+3:W];
      if (force_v) alu_v = 1'b1;
    end else begin
      alu_y = W'($urandom); alu_c_out = 1'($urandom); alu_v = 1'($urandom);
      alu_n = 1'($urandom); alu_z = 1'($urandom);
    end
    #1 check("in_ready", bus.in_ready, exp_ready);
    @(posedge clk);
    m_acc = 0;
    if (rst) begin
      model_reset();
    end else begin
      m_acc = bus.in_valid && exp_ready;
      ho = m_holding && bus.out_ready;
      if (clr_sticky) m_sticky = 2'b00;
      if (m_issuing) begin
        m_sticky = m_sticky | {alu_c_out, alu_v};
        m_y = alu_y;
        m_flags = {alu_c_out, alu_v, alu_n, alu_z};
        m_holding = 1; m_issuing = 0;
      end else if (ho) begin
        m_count = (m_count + 1) % (1 << CW);
        m_holding = 0;
      end
      if (m_acc) begin
        m_op = bus.in_opcode; m_a = bus.in_a; m_b = bus.in_b; m_c = bus.in_c_in;
        m_issuing = 1;
      end
    end
    #1;
    check("out_valid", bus.out_valid, m_holding);
    check("op_count", op_count, m_count);
    check("sticky_cv", sticky_cv, m_sticky);
    check("alu_regs", {alu_opcode, alu_a, alu_b, alu_c_in}, {m_op, m_a, m_b, m_c});
    if (m_holding) begin
      check("out_y", bus.out_y, m_y);
      check("out_flags", bus.out_flags, m_flags);
    end
  endtask

  task automatic set_op(input int op, input int a, input int b, input int c);
    bus.in_opcode = OPW'(op); bus.in_a = W'(a); bus.in_b = W'(b); bus.in_c_in = W'(c);
  endtask

  task automatic do_reset();
    rst = 1; bus.in_valid = 0; clr_sticky = 0;
    cycle(); cycle();
    rst = 0;
  endtask

  // Run until the model is issuing, bounded; expiry counts as a failure.
  task automatic wait_issuing();
    int n = 0;
    while (!m_issuing && n < 20) begin cycle(); n++; end
    check("wait_issue_timeout", m_issuing, 1);
  endtask

  int seq[5] = '{1, 2, 3, 0, 1};

  initial begin
    rst = 1; clr_sticky = 0; force_v = 0;
    bus.in_valid = 0; bus.out_ready = 0; set_op(0, 0, 0, 0);
    alu_y = '0; alu_c_out = 0; alu_v = 0; alu_n = 0; alu_z = 0;
    model_reset();
    do_reset();
    check("reset_valid", bus.out_valid, 0);
    check("reset_count", op_count, 0);

    // Single op: 3 << 1 = 6
    set_op(0, 3, 1, 0); bus.in_valid = 1; bus.out_ready = 1;
    cycle(); bus.in_valid = 0;
    cycle();
    check("single_valid", bus.out_valid, 1);
    check("single_y", bus.out_y, 3'b110);
    cycle();
    check("single_count", op_count, 1);
    check("single_idle_ready", bus.in_ready, 1);

    // Back-to-back: 3<<1 then 6>>1
    set_op(0, 3, 1, 0); bus.in_valid = 1;
    cycle(); set_op(1, 6, 1, 0);
    cycle();
    check("b2b_y1", bus.out_y, 3'd6);
    cycle(); bus.in_valid = 0;
    check("b2b_acc2", m_acc, 1);
    cycle();
    check("b2b_y2", bus.out_y, 3'd3);
    cycle();
    check("b2b_count", op_count, 3);

    // Backpressure: result held for 5 cycles while a new op waits
    set_op(2, 3, 2, 1); bus.in_valid = 1;
    cycle(); set_op(3, 1, 5, 0); bus.out_ready = 0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_not_acc", m_acc, 0);
    end
    bus.out_ready = 1;
    cycle(); bus.in_valid = 0;
    check("bp_acc", m_acc, 1);
    cycle(); cycle();

    // Sticky: clear alone, forced overflow, clear coinciding with capture, clear alone
    clr_sticky = 1; cycle(); clr_sticky = 0;
    check("sticky_clr0", sticky_cv, 2'b00);
    set_op(1, 4, 1, 0); bus.in_valid = 1; force_v = 1;
    cycle(); bus.in_valid = 0;
    cycle(); force_v = 0;
    check("sticky_set", sticky_cv, 2'b01);
    cycle();
    set_op(1, 2, 1, 0); bus.in_valid = 1;
    cycle(); bus.in_valid = 0;
    wait_issuing();
    force_v = 1; clr_sticky = 1;
    cycle(); force_v = 0; clr_sticky = 0;
    check("sticky_clr_cap", sticky_cv, 2'b01);
    clr_sticky = 1; cycle(); clr_sticky = 0;
    check("sticky_clr1", sticky_cv, 2'b00);
    cycle();

    // Reset mid-op
    do_reset();
    set_op(0, 1, 1, 0); bus.in_valid = 1;
    cycle(); bus.in_valid = 0;
    rst = 1; cycle(); rst = 0;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_ready", bus.in_ready, 1);
    check("midrst_count", op_count, 0);
    for (int i = 0; i < 4; i++) cycle();

    // Counter wrap with CW=2
    for (int i = 0; i < 5; i++) begin
      set_op(2, i, 1, 0); bus.in_valid = 1;
      cycle(); bus.in_valid = 0;
      cycle(); cycle();
      check("wrap_count", op_count, seq[i]);
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
        set_op($urandom_range(0, 5), $urandom, $urandom, $urandom);
        bus.in_valid = 1;
      end
      bus.out_ready = ($urandom_range(0, 99) < 60);
      clr_sticky    = ($urandom_range(0, 9) == 0);
      force_v       = ($urandom_range(0, 3) == 0);
      rst           = ($urandom_range(0, 149) == 0);
      cycle();
      if (m_acc || rst) bus.in_valid = 0;
      rst = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
